// File: rtl/lifo_drain.sv
// lifo_drain: pops words from a lifo stack on request and presents each one on a valid/ready stream.
// Stops after num words (0 = until empty) and pulses done when finished.
module lifo_drain #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             c,
  input  logic             r,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic             empty,
  input  logic [W-1:0]     lifo_o,
  output logic             rd,
  output logic [W-1:0]     dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] popped
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] POP   = 3'd2;
  localparam logic [2:0] LOAD  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  logic [2:0]       r_state, w_next;
  logic [CNT_W-1:0] r_req, r_popped;
  logic [W-1:0]     r_dout;
  logic             w_limit;
  assign w_limit = (r_req != '0) && (r_popped == r_req);
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? CHECK : IDLE;
      CHECK:   w_next = (empty || w_limit) ? DONE : POP;
      POP:     w_next = LOAD;
      LOAD:    w_next = OUT;
      OUT:     w_next = dready ? CHECK : OUT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_popped <= '0;
      r_dout   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_req    <= num;
        r_popped <= '0;
      end
      if (r_state == LOAD) r_dout <= lifo_o;
      if (r_state == OUT && dready) r_popped <= r_popped + 1'b1;
    end
  end
  // Handshake outputs come straight from the state register so nothing downstream sees an input-to-output path.
  assign rd     = (r_state == POP);
  assign dvalid = (r_state == OUT);
  assign done   = (r_state == DONE);
  assign busy   = (r_state != IDLE);
  assign dout   = r_dout;
  assign popped = r_popped;
endmodule

// File: tb/tb_lifo_drain.sv
// tb_lifo_drain: drives lifo_drain against a small 8x8 stack and checks the output stream against a queue model.
module tb_lifo_drain;
  logic       c = 0, r = 0, start = 0, dready = 1, wr = 0;
  logic [3:0] num = 0;
  logic [7:0] din = 0, lifo_o = 0, dout;
  logic       empty, rd, dvalid, busy, done;
  logic [3:0] popped;
  logic [7:0] mem [8];
  int         cnt = 0;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] ref_q [$];

  lifo_drain #(.W(8), .CNT_W(4)) dut (
    .c(c), .r(r), .start(start), .num(num), .empty(empty), .lifo_o(lifo_o),
    .rd(rd), .dout(dout), .dvalid(dvalid), .dready(dready), .busy(busy),
    .done(done), .popped(popped)
  );

  always #5 c = ~c;

  // Stack under the controller: write has priority, write gated by busy, not affected by reset.
  assign empty = (cnt == 0);
  always @(posedge c) begin
    if (wr && !busy && cnt < 8) begin
      mem[cnt] <= din;
      cnt <= cnt + 1;
    end else if (rd && cnt > 0) begin
      lifo_o <= mem[cnt-1];
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge c);
    wr = 1; din = d;
    @(negedge c);
    wr = 0;
    if (ref_q.size() < 8) ref_q.push_back(d);
  endtask

  // mode 0: dready always 1, 1: random dready, 2: dready held low 5 cycles at first OUT
  task automatic run(input logic [3:0] n, input int mode);
    logic [7:0] exp_q [$];
    int want, idx, rds, dns, stall;
    bit fin;
    want = (n == 0 || n > ref_q.size()) ? ref_q.size() : int'(n);
    for (int k = 0; k < want; k++) exp_q.push_back(ref_q.pop_back());
    idx = 0; rds = 0; dns = 0; stall = 0; fin = 0;
    @(negedge c);
    num = n; start = 1;
    @(negedge c);
    start = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      if (i > 0) @(negedge c);
      if (i == 4) start = 0;
      if (i == 3 && busy && !done) begin
        start = 1; num = 4'($urandom);
      end
      if (mode == 2 && dvalid && stall < 5) begin
        dready = 0; stall++;
        chk("stall_valid", 32'(dvalid), 1);
        chk("stall_dout", 32'(dout), 32'(exp_q[0]));
        chk("stall_rd", 32'(rd), 0);
      end else dready = (mode == 1) ? ($urandom % 4 != 0) : 1'b1;
      if (rd) rds++;
      if (done) begin dns++; fin = 1; end
      if (dvalid && dready) begin
        if (idx < exp_q.size()) chk("data", 32'(dout), 32'(exp_q[idx]));
        else chk("extra_word", 32'(dout), 32'hffff_ffff);
        idx++;
      end
    end
    start = 0; dready = 1;
    if (!fin) chk("timeout", 0, 1);
    chk("words", idx, want);
    chk("rd_pulses", rds, want);
    chk("done_pulses", dns, 1);
    @(negedge c);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle", 32'(busy), 0);
    chk("popped", 32'(popped), 32'(want % 16));
    chk("empty", 32'(empty), 32'(ref_q.size() == 0));
  endtask

  initial begin
    int rds, dvs;
    repeat (2) @(negedge c);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_busy", 32'(busy), 0);
    r = 1;
    @(negedge c);
    chk("rst_dvalid", 32'(dvalid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_popped", 32'(popped), 0);

    push(8'h77); push(8'h22);
    run(0, 0);
    push(8'h11); push(8'h22); push(8'h33);
    run(1, 0);
    chk("retained", cnt, 2);
    run(0, 0);
    push(8'h77); push(8'h22);
    run(0, 2);

    // Empty stack: CHECK then DONE, nothing popped; a start while busy is ignored.
    rds = 0; dvs = 0;
    @(negedge c);
    num = 0; start = 1;
    @(negedge c);
    num = 3;
    rds += rd; dvs += dvalid;
    @(negedge c);
    start = 0;
    rds += rd; dvs += dvalid;
    chk("empty_done", 32'(done), 1);
    @(negedge c);
    chk("empty_idle", 32'(busy), 0);
    chk("empty_rd", rds, 0);
    chk("empty_dvalid", dvs, 0);
    chk("empty_popped", 32'(popped), 0);

    // Asynchronous reset while a word is presented; that word is lost.
    push(8'ha1); push(8'hb2); push(8'hc3);
    @(negedge c);
    num = 0; start = 1; dready = 0;
    @(negedge c);
    start = 0;
    for (int i = 0; i < 20 && !dvalid; i++) @(negedge c);
    chk("pre_rst_dvalid", 32'(dvalid), 1);
    #2 r = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_dvalid", 32'(dvalid), 0);
    chk("arst_rd", 32'(rd), 0);
    chk("arst_dout", 32'(dout), 0);
    void'(ref_q.pop_back());
    @(negedge c);
    r = 1; dready = 1;
    chk("arst_popped", 32'(popped), 0);
    run(0, 0);

    for (int t = 0; t < 25; t++) begin
      int np;
      np = $urandom_range(0, 8 - ref_q.size());
      for (int k = 0; k < np; k++) push(8'($urandom));
      run(4'($urandom_range(0, 9)), (t % 3 == 0) ? 2 : 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
